bcd_down_counter: RTL and testbench
===================================

Name: bcd_down_counter

Overview:
- Multi-digit packed-BCD countdown counter; the decrement counterpart of the BCD incrementor.
- Loads a preset, then counts down one LSD unit per qualified tick to 0000, pulses done, and halts.
- Used for timer and countdown displays feeding seven-segment drivers.
- Borrow ripples through per-digit decrementor instances.

Parameters:
DIGITS, 4, number of BCD digits; count width = 4*DIGITS.

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous, active-high reset
i_load  input  1  load request
i_load_value  input  4*DIGITS  packed BCD preset; digit 0 in [3:0]
i_start  input  1  start/resume counting
i_stop  input  1  pause counting
i_tick  input  1  decrement enable; one-cycle strobe
o_count  output  4*DIGITS  current packed BCD count, registered
o_running  output  1  high in RUN state
o_zero  output  1  high while o_count == 0
o_done  output  1  one-cycle pulse when count reaches zero
o_load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Single clock i_clk. Reset i_rst is synchronous and active-high.
- Reset values: o_count=0, o_running=0, o_zero=1, o_done=0, o_load_err=0, state=IDLE, reload register=0.
- All outputs are registered or decoded from registers. There is no combinational input-to-output path.
- Input priority in any state: i_rst > i_load > i_stop > i_start > i_tick.
- States: IDLE, RUN, DONE.
- Load, any state:
  - If every digit of i_load_value is <=9: o_count and the reload register take the value at the edge, and the state becomes IDLE.
  - If any digit is >9: o_load_err=1 for the next cycle, and o_count and state are unchanged.
- IDLE:
  - i_start with o_count!=0 -> RUN.
  - i_start with o_count==0 -> ignored.
  - i_tick -> ignored.
- RUN:
  - i_stop -> IDLE, count held.
  - i_tick -> o_count decrements by 1 in BCD, visible the cycle after the edge.
  - Per-digit decrement: digit 0 gets borrow-in=1. A digit with borrow-in and value 0 becomes 9 and emits borrow-out; otherwise the digit decrements and borrow stops.
  - Example: 1000 -> 0999.
  - The tick that takes the count 0001 -> 0000 also moves the state to DONE.
- DONE:
  - Lasts exactly one cycle; o_done=1 during it and o_running=0.
  - Next state is IDLE.
  - i_tick and i_start in DONE are ignored.
  - i_load in DONE is honoured.
- A tick in the same cycle as i_start from IDLE is not counted. The first decrement uses the next tick sampled in RUN.
- i_stop and i_tick together in RUN: stop wins, no decrement.
- Count never underflows: a tick at 0000 is impossible in RUN by construction, and is ignored elsewhere.
- Reset mid-run clears everything to reset values on that edge.

Optional Feature:
Macro BCD_DOWN_COUNTER_AUTO_RELOAD_EN.
- Defined:
  - In DONE, the next edge loads o_count from the reload register and enters RUN; o_done still pulses for the DONE cycle.
  - If the reload register is 0, the next state is IDLE.
  - i_stop in DONE -> IDLE without reload.
- Undefined: the reload register is not synthesised and DONE always goes to IDLE.

Decomposition:
- Package bcd_pkg holds:
  - digit width 4,
  - BCD_MAX=4'd9,
  - state enum encodings IDLE/RUN/DONE,
  - a digit-validity check function.
- Sub-module bcd_decrementor, instantiated DIGITS times in a borrow chain:
  - ports i_num[3:0], i_borrow_in, o_result[3:0], o_borrow_out;
  - combinational;
  - invalid input digit gives 0000 and borrow 0.

Test Plan:
1. Load 0100, start, 1 tick -> o_count=0099, o_done=0, o_running=1.
2. Load 0003, start, 3 ticks -> o_count=0000, o_done high exactly one cycle after the 3rd tick edge, then o_running=0 and o_zero=1; 5 further ticks -> still 0000, no o_done.
3. Load 00A5 -> o_load_err one-cycle pulse, o_count keeps its prior value, state unchanged.
4. Load 0050, start, 2 ticks -> 0048; stop, 5 ticks -> 0048; start plus tick in the same cycle -> 0048; next tick -> 0047. Also stop and tick in the same cycle -> no decrement.
5. Load 1000, start, tick -> 0999. Assert i_rst mid-run -> next cycle o_count=0000, o_running=0, o_zero=1, o_done=0.
6. With BCD_DOWN_COUNTER_AUTO_RELOAD_EN: load 0002, start, 2 ticks -> 0000 with o_done pulse; next cycle o_count=0002 and o_running=1. Without the macro, state is IDLE at 0000.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, digit limit, counter state encoding and digit validation.
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  function automatic logic is_valid_digit(input logic [DIGIT_W-1:0] digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_decrementor.sv
// Single-digit BCD decrementor with borrow chaining.
// An invalid input digit produces 0 and no borrow.
module bcd_decrementor
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_num,
  input  logic               i_borrow_in,
  output logic [DIGIT_W-1:0] o_result,
  output logic               o_borrow_out
);

  always_comb begin
    o_result     = '0;
    o_borrow_out = 1'b0;
    if (is_valid_digit(i_num)) begin
      if (!i_borrow_in) begin
        o_result = i_num;
      end else if (i_num == '0) begin
        o_result     = BCD_MAX;
        o_borrow_out = 1'b1;
      end else begin
        o_result = i_num - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit packed-BCD countdown counter: load, run on ticks down to zero, pulse done, halt.
// Optional macro BCD_DOWN_COUNTER_AUTO_RELOAD_EN restarts from the last loaded value after DONE.
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_load_value,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_tick,
  output logic [4*DIGITS-1:0]   o_count,
  output logic                  o_running,
  output logic                  o_zero,
  output logic                  o_done,
  output logic                  o_load_err
);

  localparam int unsigned CountW = 4 * DIGITS;

  state_e              state_q, state_d;
  logic [CountW-1:0]   count_q, count_d;
  logic                load_err_q, load_err_d;
  logic [CountW-1:0]   dec_count;
  logic                borrow [DIGITS+1];
  logic                load_ok;

`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
  logic [CountW-1:0]   reload_q, reload_d;
`endif

  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_decrementor u_dec (
      .i_num        (count_q[DIGIT_W*i +: DIGIT_W]),
      .i_borrow_in  (borrow[i]),
      .o_result     (dec_count[DIGIT_W*i +: DIGIT_W]),
      .o_borrow_out (borrow[i+1])
    );
  end

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (!is_valid_digit(i_load_value[DIGIT_W*i +: DIGIT_W])) load_ok = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    load_err_d = 1'b0;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
    reload_d   = reload_q;
`endif
    if (i_load) begin
      if (load_ok) begin
        count_d = i_load_value;
        state_d = StIdle;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
        reload_d = i_load_value;
`endif
      end else begin
        load_err_d = 1'b1;
        // DONE is a one-cycle state even when a bad load is rejected there.
        if (state_q == StDone) state_d = StIdle;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!i_stop && i_start && (count_q != '0)) state_d = StRun;
        end
        StRun: begin
          if (i_stop) begin
            state_d = StIdle;
          end else if (i_tick && !borrow[DIGITS]) begin
            // A final borrow out of the top digit would mean underflow; never taken.
            count_d = dec_count;
            if (dec_count == '0) state_d = StDone;
          end
        end
        StDone: begin
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
          if (i_stop || (reload_q == '0)) begin
            state_d = StIdle;
          end else begin
            count_d = reload_q;
            state_d = StRun;
          end
`else
          state_d = StIdle;
`endif
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      load_err_q <= load_err_d;
    end
  end

`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) reload_q <= '0;
    else       reload_q <= reload_d;
  end
`endif

  assign o_count    = count_q;
  assign o_running  = (state_q == StRun);
  assign o_done     = (state_q == StDone);
  assign o_zero     = (count_q == '0);
  assign o_load_err = load_err_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench for bcd_down_counter: decimal reference model feeds a scoreboard queue.
module tb_bcd_down_counter;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst, load, start, stop, tick;
  logic [W-1:0] load_value;
  logic [W-1:0] count;
  logic         running, zero, done, load_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string        tag;
    logic [W-1:0] count;
    logic         running;
    logic         zero;
    logic         done;
    logic         load_err;
  } exp_t;

  exp_t sb[$];

  // Reference model state: decimal count, 0=idle 1=run 2=done.
  int m_state = 0;
  int m_cnt = 0;
  int m_reload = 0;
  bit m_err = 1'b0;

  always #5 clk = ~clk;

  bcd_down_counter #(.DIGITS(DIGITS)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_load       (load),
    .i_load_value (load_value),
    .i_start      (start),
    .i_stop       (stop),
    .i_tick       (tick),
    .o_count      (count),
    .o_running    (running),
    .o_zero       (zero),
    .o_done       (done),
    .o_load_err   (load_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit bcd_valid(input logic [W-1:0] v);
    for (int i = 0; i < int'(DIGITS); i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] r = '0;
    int x = n;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_step(input bit r, input bit ld, input logic [W-1:0] lv,
                            input bit st, input bit sp, input bit tk);
    if (r) begin
      m_state = 0; m_cnt = 0; m_reload = 0; m_err = 1'b0;
      return;
    end
    m_err = 1'b0;
    if (ld) begin
      if (bcd_valid(lv)) begin
        m_cnt = bcd2int(lv); m_reload = m_cnt; m_state = 0;
      end else begin
        m_err = 1'b1;
        if (m_state == 2) m_state = 0;
      end
    end else begin
      case (m_state)
        0: if (!sp && st && m_cnt != 0) m_state = 1;
        1: begin
          if (sp) m_state = 0;
          else if (tk && m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) m_state = 2;
          end
        end
        default: begin
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
          if (sp || m_reload == 0) m_state = 0;
          else begin m_cnt = m_reload; m_state = 1; end
`else
          m_state = 0;
`endif
        end
      endcase
    end
  endtask

  // Drive one cycle, push the model's prediction, then compare after the edge.
  task automatic cyc(input string tag, input bit r = 0, input bit ld = 0,
                     input logic [W-1:0] lv = '0, input bit st = 0, input bit sp = 0,
                     input bit tk = 0);
    exp_t e;
    rst = r; load = ld; load_value = lv; start = st; stop = sp; tick = tk;
    model_step(r, ld, lv, st, sp, tk);
    e.tag = tag;
    e.count = int2bcd(m_cnt);
    e.running = (m_state == 1);
    e.zero = (m_cnt == 0);
    e.done = (m_state == 2);
    e.load_err = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, "_count"}, 32'(count), 32'(e.count));
    check({e.tag, "_running"}, 32'(running), 32'(e.running));
    check({e.tag, "_zero"}, 32'(zero), 32'(e.zero));
    check({e.tag, "_done"}, 32'(done), 32'(e.done));
    check({e.tag, "_load_err"}, 32'(load_err), 32'(e.load_err));
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load_value = '0; start = 1'b0; stop = 1'b0; tick = 1'b0;
    cyc("reset", 1);
    cyc("reset2", 1);
    check("reset_count_const", 32'(count), 32'h0);
    check("reset_zero_const", 32'(zero), 32'h1);

    // 0100 -> 0099
    cyc("t1_load", 0, 1, 16'h0100);
    cyc("t1_start", 0, 0, '0, 1);
    cyc("t1_tick", 0, 0, '0, 0, 0, 1);
    check("t1_count_const", 32'(count), 32'h0099);
    check("t1_running_const", 32'(running), 32'h1);

    // Countdown to zero and halt
    cyc("t2_load", 0, 1, 16'h0003);
    cyc("t2_start", 0, 0, '0, 1);
    for (int i = 0; i < 3; i++) cyc("t2_tick", 0, 0, '0, 0, 0, 1);
    check("t2_done_const", 32'(done), 32'h1);
    check("t2_count_const", 32'(count), 32'h0);
    cyc("t2_post");
`ifndef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
    check("t2_post_running_const", 32'(running), 32'h0);
    check("t2_post_zero_const", 32'(zero), 32'h1);
`endif
    for (int i = 0; i < 5; i++) cyc("t2_extra_tick", 0, 0, '0, 0, 0, 1);

    // Rejected loads
    cyc("t3_pre_load", 0, 1, 16'h0042);
    cyc("t3_bad_low", 0, 1, 16'h00A5);
    check("t3_err_const", 32'(load_err), 32'h1);
    check("t3_keep_const", 32'(count), 32'h0042);
    cyc("t3_after");
    cyc("t3_bad_high", 0, 1, 16'hF000);
    cyc("t3_start", 0, 0, '0, 1);

    // Stop / resume behaviour
    cyc("t4_load", 0, 1, 16'h0050);
    cyc("t4_start", 0, 0, '0, 1);
    cyc("t4_tick", 0, 0, '0, 0, 0, 1);
    cyc("t4_tick", 0, 0, '0, 0, 0, 1);
    cyc("t4_stop", 0, 0, '0, 0, 1);
    for (int i = 0; i < 5; i++) cyc("t4_idle_tick", 0, 0, '0, 0, 0, 1);
    check("t4_hold_const", 32'(count), 32'h0048);
    cyc("t4_start_tick", 0, 0, '0, 1, 0, 1);
    check("t4_start_tick_const", 32'(count), 32'h0048);
    cyc("t4_tick2", 0, 0, '0, 0, 0, 1);
    check("t4_dec_const", 32'(count), 32'h0047);
    cyc("t4_stop_tick", 0, 0, '0, 0, 1, 1);
    check("t4_stop_tick_const", 32'(count), 32'h0047);

    // Multi-digit borrow, then reset mid-run
    cyc("t5_load", 0, 1, 16'h1000);
    cyc("t5_start", 0, 0, '0, 1);
    cyc("t5_tick", 0, 0, '0, 0, 0, 1);
    check("t5_borrow_const", 32'(count), 32'h0999);
    cyc("t5_rst", 1, 0, '0, 0, 0, 1);
    check("t5_rst_running_const", 32'(running), 32'h0);
    check("t5_rst_zero_const", 32'(zero), 32'h1);

    // Behaviour after DONE
    cyc("t6_load", 0, 1, 16'h0002);
    cyc("t6_start", 0, 0, '0, 1);
    cyc("t6_tick", 0, 0, '0, 0, 0, 1);
    cyc("t6_tick", 0, 0, '0, 0, 0, 1);
    check("t6_done_const", 32'(done), 32'h1);
    cyc("t6_after");
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
    check("t6_reload_const", 32'(count), 32'h0002);
    check("t6_running_const", 32'(running), 32'h1);
`else
    check("t6_idle_count_const", 32'(count), 32'h0);
    check("t6_idle_running_const", 32'(running), 32'h0);
`endif
    for (int i = 0; i < 3; i++) cyc("t6_tail_tick", 0, 0, '0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
